// File: rtl/cpu_watchdog_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cpu_watchdog_pkg                                             |
// | Description : Shared types and default parameter values for the CPU        |
// |               watchdog (channel FSM state encoding, default sizes).        |
// | Ports       : none (package)                                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package cpu_watchdog_pkg;

   // Per-channel watchdog state
   typedef enum logic [1:0] {
      WD_IDLE    = 2'd0,
      WD_COUNT   = 2'd1,
      WD_EXPIRED = 2'd2
   } wd_state_t;

   // Default parameter values for the top level
   localparam int c_def_channels      = 2;
   localparam int c_def_counter_width = 12;
   localparam int c_def_warn_margin   = 16;
   localparam int c_def_pc_width      = 32;
   localparam int c_def_halt_repeat   = 8;

endpackage : cpu_watchdog_pkg
`default_nettype wire

// File: rtl/cpu_watchdog_wd_channel.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : wd_channel                                                   |
// | Description : One kickable watchdog channel: timeout register, down        |
// |               counter, IDLE/COUNT/EXPIRED state machine and pre-timeout    |
// |               warning.                                                     |
// | Ports       : clk, rst       - clock, synchronous active-high reset        |
// |               i_load         - latch i_timeout into the timeout register   |
// |               i_timeout      - timeout value                               |
// |               i_enable       - channel runs while high                     |
// |               i_kick         - reload the counter while counting           |
// |               i_clear        - acknowledge an expired channel              |
// |               o_remaining    - current counter value                       |
// |               o_warn         - counting and remaining <= WARN_MARGIN       |
// |               o_expired      - channel is in EXPIRED                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module wd_channel
   import cpu_watchdog_pkg::*;
#(
   parameter int COUNTER_WIDTH = c_def_counter_width,
   parameter int WARN_MARGIN   = c_def_warn_margin
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_load,
   input  logic [COUNTER_WIDTH-1:0] i_timeout,
   input  logic                     i_enable,
   input  logic                     i_kick,
   input  logic                     i_clear,
   output logic [COUNTER_WIDTH-1:0] o_remaining,
   output logic                     o_warn,
   output logic                     o_expired
);

   wd_state_t                r_state;
   wd_state_t                w_state_nxt;
   logic [COUNTER_WIDTH-1:0] r_counter;
   logic [COUNTER_WIDTH-1:0] w_counter_nxt;
   logic [COUNTER_WIDTH-1:0] r_timeout;

   // Timeout register: a new value only takes effect at the next start/kick,
   // because the counter always reloads from the registered copy.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_timeout <= '1;
      end else if (i_load) begin
         r_timeout <= i_timeout;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= WD_IDLE;
         r_counter <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_counter <= w_counter_nxt;
      end
   end

   // Next state / counter. In COUNT the priority is
   // disable > kick > expiry > decrement, so a kick on the zero cycle
   // reloads instead of expiring and the counter never wraps.
   always_comb begin
      w_state_nxt   = r_state;
      w_counter_nxt = r_counter;
      case (r_state)
         WD_IDLE: begin
            if (i_enable) begin
               w_state_nxt   = WD_COUNT;
               w_counter_nxt = r_timeout;
            end
         end
         WD_COUNT: begin
            if (!i_enable) begin
               w_state_nxt   = WD_IDLE;
               w_counter_nxt = '0;
            end else if (i_kick) begin
               w_counter_nxt = r_timeout;
            end else if (r_counter == '0) begin
               w_state_nxt = WD_EXPIRED;
            end else begin
               w_counter_nxt = r_counter - 1'b1;
            end
         end
         WD_EXPIRED: begin
            // Kick and enable are ignored here; only clear leaves.
            w_counter_nxt = '0;
            if (i_clear) begin
               w_state_nxt = WD_IDLE;
            end
         end
         default: begin
            w_state_nxt   = WD_IDLE;
            w_counter_nxt = '0;
         end
      endcase
   end

   assign o_remaining = r_counter;
   assign o_warn      = (r_state == WD_COUNT) && (32'(r_counter) <= WARN_MARGIN);
   assign o_expired   = (r_state == WD_EXPIRED);

endmodule : wd_channel
`default_nettype wire

// File: rtl/cpu_watchdog.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cpu_watchdog                                                 |
// | Description : Multi-channel kickable watchdog with pre-timeout warning     |
// |               plus a PC halt detector (PC stuck at one address).           |
// | Ports       : clk, s_reset   - clock, synchronous active-high reset        |
// |               cfg_load       - per-channel timeout latch strobe            |
// |               cfg_timeout    - shared timeout value                        |
// |               ch_enable/kick/clear - per-channel controls                  |
// |               pc_valid, pc   - monitored program counter                   |
// |               remaining      - packed counters, channel i at i*CW          |
// |               ch_warn, ch_expired - per-channel status                     |
// |               halt_detected  - sticky halt flag                            |
// |               any_fault      - registered OR of all faults                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module cpu_watchdog
   import cpu_watchdog_pkg::*;
#(
   parameter int CHANNELS      = c_def_channels,
   parameter int COUNTER_WIDTH = c_def_counter_width,
   parameter int WARN_MARGIN   = c_def_warn_margin,
   parameter int PC_WIDTH      = c_def_pc_width,
   parameter int HALT_REPEAT   = c_def_halt_repeat
) (
   input  logic                              clk,
   input  logic                              s_reset,
   input  logic [CHANNELS-1:0]               cfg_load,
   input  logic [COUNTER_WIDTH-1:0]          cfg_timeout,
   input  logic [CHANNELS-1:0]               ch_enable,
   input  logic [CHANNELS-1:0]               ch_kick,
   input  logic [CHANNELS-1:0]               ch_clear,
   input  logic                              pc_valid,
   input  logic [PC_WIDTH-1:0]               pc,
   output logic [CHANNELS*COUNTER_WIDTH-1:0] remaining,
   output logic [CHANNELS-1:0]               ch_warn,
   output logic [CHANNELS-1:0]               ch_expired,
   output logic                              halt_detected,
   output logic                              any_fault
);

   localparam int                c_halt_w   = $clog2(HALT_REPEAT + 1);
   localparam logic [c_halt_w-1:0] c_halt_max = c_halt_w'(HALT_REPEAT);

   logic [CHANNELS-1:0] w_expired;

   for (genvar g = 0; g < CHANNELS; g++) begin : g_channel
      wd_channel #(
         .COUNTER_WIDTH (COUNTER_WIDTH),
         .WARN_MARGIN   (WARN_MARGIN)
      ) u_channel (
         .clk         (clk),
         .rst         (s_reset),
         .i_load      (cfg_load[g]),
         .i_timeout   (cfg_timeout),
         .i_enable    (ch_enable[g]),
         .i_kick      (ch_kick[g]),
         .i_clear     (ch_clear[g]),
         .o_remaining (remaining[g*COUNTER_WIDTH +: COUNTER_WIDTH]),
         .o_warn      (ch_warn[g]),
         .o_expired   (w_expired[g])
      );
   end

   assign ch_expired = w_expired;

   // ---------------- Halt detector ----------------
   logic [PC_WIDTH-1:0] r_last_pc;
   logic [c_halt_w-1:0] r_halt_cnt;
   logic [c_halt_w-1:0] w_halt_cnt_nxt;
   logic                w_pc_same;
   logic                r_halt;

   // A zero count means no valid sample yet since reset, so the reset value
   // of r_last_pc is never treated as a real previous PC.
   always_comb begin
      w_pc_same      = (r_halt_cnt != '0) && (pc == r_last_pc);
      w_halt_cnt_nxt = c_halt_w'(1);
      if (w_pc_same) begin
         w_halt_cnt_nxt = (r_halt_cnt == c_halt_max) ? r_halt_cnt
                                                     : r_halt_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (s_reset) begin
         r_last_pc  <= '0;
         r_halt_cnt <= '0;
         r_halt     <= 1'b0;
      end else if (pc_valid) begin
         r_last_pc  <= pc;
         r_halt_cnt <= w_halt_cnt_nxt;
         if (w_halt_cnt_nxt == c_halt_max) begin
            r_halt <= 1'b1;
         end
      end
   end

   assign halt_detected = r_halt;

   // ---------------- Fault summary ----------------
   logic r_any_fault;

   always_ff @(posedge clk) begin
      if (s_reset) begin
         r_any_fault <= 1'b0;
      end else begin
         r_any_fault <= (|w_expired) | r_halt;
      end
   end

   assign any_fault = r_any_fault;

endmodule : cpu_watchdog
`default_nettype wire

// File: tb/tb_cpu_watchdog.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_cpu_watchdog                                              |
// | Description : Self-checking bench for cpu_watchdog: directed scenarios     |
// |               followed by randomized traffic, all outputs compared every   |
// |               cycle against a behavioural model.                           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_cpu_watchdog;

   localparam int CH = 2;
   localparam int CW = 12;
   localparam int WM = 16;
   localparam int PW = 32;
   localparam int HR = 8;

   logic                clk = 1'b0;
   logic                s_reset;
   logic [CH-1:0]       cfg_load;
   logic [CW-1:0]       cfg_timeout;
   logic [CH-1:0]       ch_enable;
   logic [CH-1:0]       ch_kick;
   logic [CH-1:0]       ch_clear;
   logic                pc_valid;
   logic [PW-1:0]       pc;
   logic [CH*CW-1:0]    remaining;
   logic [CH-1:0]       ch_warn;
   logic [CH-1:0]       ch_expired;
   logic                halt_detected;
   logic                any_fault;

   always #5 clk = ~clk;

   cpu_watchdog #(
      .CHANNELS      (CH),
      .COUNTER_WIDTH (CW),
      .WARN_MARGIN   (WM),
      .PC_WIDTH      (PW),
      .HALT_REPEAT   (HR)
   ) dut (
      .clk           (clk),
      .s_reset       (s_reset),
      .cfg_load      (cfg_load),
      .cfg_timeout   (cfg_timeout),
      .ch_enable     (ch_enable),
      .ch_kick       (ch_kick),
      .ch_clear      (ch_clear),
      .pc_valid      (pc_valid),
      .pc            (pc),
      .remaining     (remaining),
      .ch_warn       (ch_warn),
      .ch_expired    (ch_expired),
      .halt_detected (halt_detected),
      .any_fault     (any_fault)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- Reference model ----------------
   // Channel: running/expired flags plus remaining count and timeout value.
   // Halt: length of the current run of equal valid PC samples.
   int          m_tmo     [CH];
   int          m_rem     [CH];
   bit          m_running [CH];
   bit          m_expired [CH];
   int          m_run;
   logic [PW-1:0] m_last;
   bit          m_halt;
   bit          m_fault;

   task automatic model_edge();
      bit any_exp;
      int old_t;
      if (s_reset) begin
         for (int i = 0; i < CH; i++) begin
            m_tmo[i] = 4095; m_rem[i] = 0; m_running[i] = 0; m_expired[i] = 0;
         end
         m_run = 0; m_last = '0; m_halt = 0; m_fault = 0;
      end else begin
         any_exp = 0;
         for (int i = 0; i < CH; i++) any_exp |= m_expired[i];
         m_fault = any_exp || m_halt;
         for (int i = 0; i < CH; i++) begin
            old_t = m_tmo[i];
            if (cfg_load[i]) m_tmo[i] = int'(cfg_timeout);
            if (m_expired[i]) begin
               m_rem[i] = 0;
               if (ch_clear[i]) m_expired[i] = 0;
            end else if (!m_running[i]) begin
               if (ch_enable[i]) begin m_running[i] = 1; m_rem[i] = old_t; end
            end else if (!ch_enable[i]) begin
               m_running[i] = 0; m_rem[i] = 0;
            end else if (ch_kick[i]) begin
               m_rem[i] = old_t;
            end else if (m_rem[i] == 0) begin
               m_running[i] = 0; m_expired[i] = 1;
            end else begin
               m_rem[i] = m_rem[i] - 1;
            end
         end
         if (pc_valid) begin
            if (m_run > 0 && pc == m_last) m_run++;
            else m_run = 1;
            m_last = pc;
            if (m_run >= HR) m_halt = 1;
         end
      end
   endtask

   task automatic compare_all();
      for (int i = 0; i < CH; i++) begin
         check($sformatf("rem%0d", i), 64'(remaining[i*CW +: CW]), 64'(m_rem[i]));
         check($sformatf("warn%0d", i), 64'(ch_warn[i]), 64'(m_running[i] && m_rem[i] <= WM));
         check($sformatf("exp%0d", i), 64'(ch_expired[i]), 64'(m_expired[i]));
      end
      check("halt", 64'(halt_detected), 64'(m_halt));
      check("fault", 64'(any_fault), 64'(m_fault));
   endtask

   // One clock: DUT and model both advance on the rising edge, outputs are
   // compared on the falling edge, and the caller drives new inputs afterwards.
   task automatic cycle();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare_all();
   endtask

   task automatic do_reset();
      s_reset = 1'b1;
      cycle();
      s_reset = 1'b0;
   endtask

   initial begin
      s_reset = 1'b1; cfg_load = '0; cfg_timeout = '0; ch_enable = '0;
      ch_kick = '0; ch_clear = '0; pc_valid = 1'b0; pc = '0;
      m_run = 0; m_last = '0; m_halt = 0; m_fault = 0;
      for (int i = 0; i < CH; i++) begin
         m_tmo[i] = 0; m_rem[i] = 0; m_running[i] = 0; m_expired[i] = 0;
      end

      // 1. Reset and default timeout
      @(negedge clk);
      do_reset();
      check("rst_remaining", 64'(remaining), 64'd0);
      check("rst_fault", 64'(any_fault), 64'd0);
      ch_enable = 2'b01;
      cycle();
      check("default_start", 64'(remaining[CW-1:0]), 64'd4095);

      // 2. Timeout 40: warning, expiry, fault
      ch_enable = 2'b00; cfg_load = 2'b01; cfg_timeout = 12'd40;
      cycle();
      cfg_load = 2'b00; ch_enable = 2'b01;
      cycle();
      check("load40", 64'(remaining[CW-1:0]), 64'd40);
      repeat (23) cycle();
      check("warn_before", 64'(ch_warn[0]), 64'd0);
      cycle();
      check("warn_at16", 64'(ch_warn[0]), 64'd1);
      repeat (16) cycle();
      check("zero_not_expired", 64'(ch_expired[0]), 64'd0);
      cycle();
      check("expired", 64'(ch_expired[0]), 64'd1);
      check("fault_lag", 64'(any_fault), 64'd0);
      cycle();
      check("fault", 64'(any_fault), 64'd1);
      check("ch1_idle", 64'(remaining[2*CW-1:CW]), 64'd0);

      // 4. Clear beats kick, enable held restarts; kick alone in EXPIRED ignored
      ch_clear = 2'b01; ch_kick = 2'b01;
      cycle();
      ch_clear = 2'b00; ch_kick = 2'b00;
      check("cleared", 64'(ch_expired[0]), 64'd0);
      cycle();
      check("restart40", 64'(remaining[CW-1:0]), 64'd40);

      // 3. Kick at 5 and at 0
      for (int k = 0; k < 100 && m_rem[0] != 5; k++) cycle();
      check("at5", 64'(remaining[CW-1:0]), 64'd5);
      ch_kick = 2'b01;
      cycle();
      ch_kick = 2'b00;
      check("kick5", 64'(remaining[CW-1:0]), 64'd40);
      check("kick5_warn", 64'(ch_warn[0]), 64'd0);
      for (int k = 0; k < 100 && m_rem[0] != 0; k++) cycle();
      check("at0", 64'(remaining[CW-1:0]), 64'd0);
      ch_kick = 2'b01;
      cycle();
      ch_kick = 2'b00;
      check("kick0", 64'(remaining[CW-1:0]), 64'd40);
      check("kick0_noexp", 64'(ch_expired[0]), 64'd0);
      for (int k = 0; k < 100 && !m_expired[0]; k++) cycle();
      ch_kick = 2'b01;
      cycle();
      ch_kick = 2'b00;
      check("kick_in_exp", 64'(ch_expired[0]), 64'd1);
      ch_enable = 2'b00; ch_clear = 2'b01;
      cycle();
      ch_clear = 2'b00;

      // 5. Halt detector with gaps, then with a different PC injected
      do_reset();
      pc = 32'h40;
      for (int k = 0; k < HR; k++) begin
         pc_valid = 1'b1; cycle();
         check("halt_seq", 64'(halt_detected), 64'(k == HR - 1));
         pc_valid = 1'b0; cycle();
      end
      do_reset();
      for (int k = 0; k < 14; k++) begin
         pc = (k < 6) ? 32'h40 : 32'h44;
         pc_valid = 1'b1; cycle();
         check("halt_inject", 64'(halt_detected), 64'(k == 13));
         pc_valid = 1'b0; cycle();
      end

      // 6. Reset mid-count overrides load and kick
      do_reset();
      cfg_load = 2'b01; cfg_timeout = 12'd40;
      cycle();
      cfg_load = 2'b00; ch_enable = 2'b01;
      for (int k = 0; k < 100 && m_rem[0] != 20; k++) cycle();
      check("at20", 64'(remaining[CW-1:0]), 64'd20);
      s_reset = 1'b1; cfg_load = 2'b11; cfg_timeout = 12'd7; ch_kick = 2'b01;
      cycle();
      check("midrst_rem", 64'(remaining), 64'd0);
      check("midrst_warn", 64'(ch_warn), 64'd0);
      s_reset = 1'b0; cfg_load = 2'b00; ch_kick = 2'b00;
      cycle();
      check("restart4095", 64'(remaining[CW-1:0]), 64'd4095);

      // Randomized traffic
      ch_enable = '0;
      for (int n = 0; n < 3000; n++) begin
         s_reset     = ($urandom_range(0, 499) == 0);
         cfg_timeout = CW'($urandom_range(0, 60));
         for (int i = 0; i < CH; i++) begin
            cfg_load[i] = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 59) == 0) ch_enable[i] = ~ch_enable[i];
            ch_kick[i]  = ($urandom_range(0, 29) == 0);
            ch_clear[i] = ($urandom_range(0, 7) == 0);
         end
         pc_valid = $urandom_range(0, 1) == 1;
         pc       = ($urandom_range(0, 5) == 0) ? 32'h44 : 32'h40;
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_cpu_watchdog
`default_nettype wire
